conv_host_12_5: RTL and testbench

CONV_HOST_12_5 -- requirements
Module: conv_host_12_5

---
 rtl/conv_host_12_5.sv | 185 ++++++++++++++++++
 tb/tb_conv_host_12_5.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_12_5.sv
// conv_host_12_5: host-side sequencer for a streaming 1-D convolution engine.
// Holds the x samples (M), the filter taps (N) and the results (R = M-N+1).
// A run streams all x samples and then all f taps to the engine, and then
// collects R results into the result memory.
// Optional feature macro: CONV_HOST_BACKPRESSURE_EN. When it is defined,
// y_ready toggles every COLLECT cycle, starting at 0, so the engine sees stalls.
module conv_host_12_5 #(
    parameter int M   = 12,
    parameter int N   = 5,
    parameter int R   = M - N + 1,
    parameter int DW  = 10,
    parameter int YW  = 23,
    parameter int LAW = $clog2(M),
    parameter int FAW = $clog2(N),
    parameter int RAW = $clog2(R)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_wr_en,
    input  logic                  ld_sel,
    input  logic [LAW-1:0]        ld_addr,
    input  logic signed [DW-1:0]  ld_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic signed [DW-1:0]  x_data,
    output logic                  x_valid,
    input  logic                  x_ready,
    output logic signed [DW-1:0]  f_data,
    output logic                  f_valid,
    input  logic                  f_ready,
    input  logic signed [YW-1:0]  y_data,
    input  logic                  y_valid,
    output logic                  y_ready,
    input  logic [RAW-1:0]        rd_addr,
    output logic signed [YW-1:0]  rd_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_X  = 3'd1,
        SEND_F  = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [LAW-1:0] xcnt_q, xcnt_d;
    logic [FAW-1:0] fcnt_q, fcnt_d;
    logic [RAW-1:0] ycnt_q, ycnt_d;
`ifdef CONV_HOST_BACKPRESSURE_EN
    logic           ytog_q, ytog_d;
`endif

    // Storage: plain register arrays, read combinationally, never reset so
    // that loaded data and captured results survive an aborted run.
    logic signed [DW-1:0] xmem_q [M];
    logic signed [DW-1:0] fmem_q [N];
    logic signed [YW-1:0] rmem_q [R];

    logic x_we, f_we, r_we;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign x_data  = xmem_q[xcnt_q];
    assign f_data  = fmem_q[fcnt_q];
    assign rd_data = rmem_q[rd_addr];

    // Load-port decode: loads only while idle and only to in-range addresses.
    always_comb begin
        x_we = 1'b0;
        f_we = 1'b0;
        if (ld_wr_en && !busy) begin
            if (!ld_sel && (ld_addr < LAW'(M)))
                x_we = 1'b1;
            if (ld_sel && (ld_addr < LAW'(N)))
                f_we = 1'b1;
        end
    end

    // Memory writes: load port into x/f memories, engine results into rmem.
    always_ff @(posedge clk) begin
        if (x_we)
            xmem_q[ld_addr] <= ld_data;
        if (f_we)
            fmem_q[ld_addr[FAW-1:0]] <= ld_data;
        if (r_we)
            rmem_q[ycnt_q] <= y_data;
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            xcnt_q  <= '0;
            fcnt_q  <= '0;
            ycnt_q  <= '0;
`ifdef CONV_HOST_BACKPRESSURE_EN
            ytog_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xcnt_q  <= xcnt_d;
            fcnt_q  <= fcnt_d;
            ycnt_q  <= ycnt_d;
`ifdef CONV_HOST_BACKPRESSURE_EN
            ytog_q  <= ytog_d;
`endif
        end
    end

    // Next-state, counter and handshake logic for the run sequencer.
    always_comb begin
        state_d = state_q;
        xcnt_d  = xcnt_q;
        fcnt_d  = fcnt_q;
        ycnt_d  = ycnt_q;
`ifdef CONV_HOST_BACKPRESSURE_EN
        ytog_d  = ytog_q;
`endif
        x_valid = 1'b0;
        f_valid = 1'b0;
        y_ready = 1'b0;
        r_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND_X;
                    xcnt_d  = '0;
                    fcnt_d  = '0;
                    ycnt_d  = '0;
                end
            end
            SEND_X: begin
                x_valid = 1'b1;
                if (x_ready) begin
                    if (xcnt_q == LAW'(M - 1)) begin
                        state_d = SEND_F;
                        xcnt_d  = '0;
                    end else begin
                        xcnt_d = xcnt_q + 1'b1;
                    end
                end
            end
            SEND_F: begin
                f_valid = 1'b1;
                if (f_ready) begin
                    if (fcnt_q == FAW'(N - 1)) begin
                        state_d = COLLECT;
                        fcnt_d  = '0;
`ifdef CONV_HOST_BACKPRESSURE_EN
                        ytog_d  = 1'b0;
`endif
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            COLLECT: begin
`ifdef CONV_HOST_BACKPRESSURE_EN
                y_ready = ytog_q;
                ytog_d  = ~ytog_q;
`else
                y_ready = 1'b1;
`endif
                if (y_valid && y_ready) begin
                    r_we = 1'b1;
                    if (ycnt_q == RAW'(R - 1)) begin
                        state_d = DONE;
                        ycnt_d  = '0;
                    end else begin
                        ycnt_d = ycnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_host_12_5.sv
// Self-checking bench for conv_host_12_5. The bench plays the engine:
// it accepts the x and f streams, computes y[k] = sum_j x[k+j]*f[j] from what
// it received, and returns the results. Expected results come from the bench's
// own copy of the loaded data and are queued before each run.
module tb_conv_host_12_5;
    localparam int M = 12;
    localparam int N = 5;
    localparam int R = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_wr_en, ld_sel;
    logic [3:0]  ld_addr;
    logic [9:0]  ld_data;
    logic        start, busy, done;
    logic [9:0]  x_data, f_data;
    logic        x_valid, x_ready, f_valid, f_ready;
    logic [22:0] y_data;
    logic        y_valid, y_ready;
    logic [2:0]  rd_addr;
    logic [22:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int xm[M];
    int fm[N];
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    conv_host_12_5 dut (
        .clk(clk), .reset(reset),
        .ld_wr_en(ld_wr_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic load(input bit sel, input int addr, input int val);
        @(negedge clk);
        ld_wr_en = 1'b1;
        ld_sel   = sel;
        ld_addr  = addr[3:0];
        ld_data  = val[9:0];
        @(negedge clk);
        ld_wr_en = 1'b0;
        if (!sel && addr < M) xm[addr] = val;
        if (sel && addr < N)  fm[addr] = val;
    endtask

    task automatic push_expected();
        int s;
        for (int k = 0; k < R; k++) begin
            s = 0;
            for (int j = 0; j < N; j++) s += xm[k + j] * fm[j];
            exp_q.push_back(s[22:0]);
        end
    endtask

    task automatic compare_results(input string tag);
        logic [22:0] e;
        for (int k = 0; k < R; k++) begin
            rd_addr = k[2:0];
            #1;
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_rmem%0d", tag, k), rd_data, e);
            end
        end
    endtask

    // One run acting as the engine. stall_x holds x_ready low for 3 cycles
    // after 4 x transfers; abort_f resets after 2 f transfers; disturb pokes
    // the load port and start during COLLECT; chk_lat checks start-to-done.
    task automatic run_conv(input string tag, input bit stall_x, input bit abort_f,
                            input bit disturb, input bit chk_lat);
        int rx[M];
        int rf[N];
        int nx = 0, nf = 0, ny = 0, ndone = 0, nstall = 0, done_cyc = -1, yv;
        bit disturbed = 0, hold;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            start    = (cyc == 0);
            ld_wr_en = 1'b0;
            if (abort_f && nf == 2) begin
                x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0;
                reset = 1'b1;
                #1;
                check({tag, "_abort_x_valid"}, x_valid, 0);
                check({tag, "_abort_f_valid"}, f_valid, 0);
                check({tag, "_abort_busy"}, busy, 0);
                check({tag, "_abort_done"}, done, 0);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check({tag, "_after_abort_done"}, done, 0);
                $display("run %s: aborted during SEND_F after %0d x, %0d f", tag, nx, nf);
                return;
            end
            check({tag, "_valid_excl"}, x_valid & f_valid, 0);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (ndone > 0 && cyc > done_cyc + 3) break;
            // engine result side, based on transfers already completed
            if (nx == M && nf == N && ny < R) begin
                yv = 0;
                for (int j = 0; j < N; j++) yv += rx[ny + j] * rf[j];
                y_valid = 1'b1;
                y_data  = yv[22:0];
                if (y_ready) ny++;
                if (disturb && !disturbed && ny == 2) begin
                    disturbed = 1;
                    ld_wr_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 10'h39C;
                    start = 1'b1;
                end
            end else if (ny < R) begin
                y_valid = 1'b1;
                y_data  = 23'h5A5A5;
                check({tag, "_y_ready_outside"}, y_ready, 0);
            end else begin
                y_valid = 1'b0;
            end
            // x side
            hold = stall_x && nx == 4 && nstall < 3;
            x_ready = !hold;
            if (hold) begin
                check({tag, "_stall_x_valid"}, x_valid, 1);
                check({tag, "_stall_x_data"}, x_data, xm[4][9:0]);
                nstall++;
            end
            if (x_valid && x_ready) begin
                if (nx < M) rx[nx] = int'($signed(x_data));
                nx++;
            end
            // f side
            f_ready = 1'b1;
            if (f_valid && f_ready) begin
                if (nf < N) rf[nf] = int'($signed(f_data));
                nf++;
            end
            @(negedge clk);
        end
        start = 1'b0; x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0; ld_wr_en = 1'b0;
        check({tag, "_x_count"}, nx, M);
        check({tag, "_f_count"}, nf, N);
        check({tag, "_y_count"}, ny, R);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_busy_after"}, busy, 0);
`ifndef CONV_HOST_BACKPRESSURE_EN
        if (chk_lat) check({tag, "_latency"}, done_cyc, M + N + R + 1);
`endif
        $display("run %s: x=%0d f=%0d y=%0d done_pulses=%0d done_cycle=%0d",
                 tag, nx, nf, ny, ndone, done_cyc);
    endtask

    initial begin
        reset = 1'b1; ld_wr_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0; y_data = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x_valid", x_valid, 0);
        check("rst_f_valid", f_valid, 0);
        check("rst_y_ready", y_ready, 0);
        reset = 1'b0;

        // ramp x with unit box filter: 15,20,...,50
        for (int i = 0; i < M; i++) load(0, i, i + 1);
        for (int j = 0; j < N; j++) load(1, j, 1);
        load(1, 7, 99);  // out of range for f, dropped
        push_expected();
        check("model_box_first", exp_q[0], 15);
        check("model_box_last", exp_q[R-1], 50);
        run_conv("box", 0, 0, 0, 1);
        compare_results("box");

        // identity filter: rmem[k] = k+1
        load(1, 0, 1);
        for (int j = 1; j < N; j++) load(1, j, 0);
        push_expected();
        run_conv("ident", 0, 0, 0, 1);
        compare_results("ident");

        // random signed data with x_ready stall at xcnt=4
        for (int i = 0; i < M; i++) load(0, i, $urandom_range(1023) - 512);
        for (int j = 0; j < N; j++) load(1, j, $urandom_range(1023) - 512);
        push_expected();
        run_conv("stall", 1, 0, 0, 0);
        compare_results("stall");

        // extreme negatives: every result 1310720
        for (int i = 0; i < M; i++) load(0, i, -512);
        for (int j = 0; j < N; j++) load(1, j, -512);
        push_expected();
        check("model_extreme", exp_q[0], 1310720);
        run_conv("extreme", 0, 0, 0, 1);
        compare_results("extreme");

        // reset during SEND_F, then a clean run with memories preserved
        for (int i = 0; i < M; i++) load(0, i, i + 1);
        for (int j = 0; j < N; j++) load(1, j, j + 1);
        run_conv("abort", 0, 1, 0, 0);
        push_expected();
        run_conv("post_abort", 0, 0, 0, 1);
        compare_results("post_abort");

        // load and start poked during COLLECT are ignored
        push_expected();
        run_conv("disturb", 0, 0, 1, 0);
        compare_results("disturb");
        push_expected();
        run_conv("after_disturb", 0, 0, 0, 1);
        compare_results("after_disturb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
